// File: rtl/mem_arb.sv
// mem_arb: arbitrates an instruction-fetch port and a load/store port onto a
// single memory port, one access outstanding at a time.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN (alternate grants on conflict;
// when undefined, data always wins a simultaneous request).
module mem_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        res,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_read,
    output logic        instr_valid,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_write,
    input  logic        data_write_enable,
    input  logic [3:0]  data_be,
    output logic [31:0] data_read,
    output logic        data_valid,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               served_data_q, served_data_d;
    logic               err_q, err_d;
    logic [31:0]        iread_q, iread_d;
    logic [31:0]        dread_q, dread_d;
    logic               in_gnt;
    logic               timeout_fire;
    logic               done;
    logic               grant_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic               last_data_q, last_data_d;
`endif

    assign in_gnt = (state_q == GNT_I) || (state_q == GNT_D);

    // Timeout fires on the last allowed grant cycle; a same-cycle mem_valid wins.
    always_comb begin
        timeout_fire = 1'b0;
        if (TIMEOUT_CYCLES != 0) begin
            timeout_fire = !mem_valid && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        end
        done = mem_valid || timeout_fire;
    end

    // Arbitration between simultaneous requests.
    always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        grant_data = data_req && (!instr_req || !last_data_q);
`else
        grant_data = data_req;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d = GNT_D;
                end else if (instr_req) begin
                    state_d = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (done) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_be      = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        instr_valid = 1'b0;
        data_valid  = 1'b0;
        bus_err     = 1'b0;
        case (state_q)
            GNT_I: begin
                mem_req  = 1'b1;
                mem_addr = instr_addr;
                mem_be   = 4'hF;
            end
            GNT_D: begin
                mem_req   = 1'b1;
                mem_addr  = data_addr;
                mem_we    = data_write_enable;
                mem_be    = data_be;
                mem_wdata = data_write;
            end
            RESP: begin
                instr_valid = !served_data_q;
                data_valid  = served_data_q;
                bus_err     = err_q;
            end
            default: ;
        endcase
    end

    // Datapath next values: wait counter, response capture, grant history.
    always_comb begin
        cnt_d         = '0;
        served_data_d = served_data_q;
        err_d         = err_q;
        iread_d       = iread_q;
        dread_d       = dread_q;
        if (in_gnt && !done && (TIMEOUT_CYCLES != 0)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (in_gnt && done) begin
            served_data_d = (state_q == GNT_D);
            err_d         = timeout_fire;
            if (state_q == GNT_I) begin
                iread_d = mem_valid ? mem_rdata : '0;
            end else if (!mem_valid) begin
                dread_d = '0;
            end else if (!data_write_enable) begin
                dread_d = mem_rdata;
            end
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_data_d = last_data_q;
        if (state_q == RESP) begin
            last_data_d = served_data_q;
        end
`endif
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q         <= '0;
            served_data_q <= 1'b0;
            err_q         <= 1'b0;
            iread_q       <= '0;
            dread_q       <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data_q   <= 1'b0;
`endif
        end else begin
            cnt_q         <= cnt_d;
            served_data_q <= served_data_d;
            err_q         <= err_d;
            iread_q       <= iread_d;
            dread_q       <= dread_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data_q   <= last_data_d;
`endif
        end
    end

    assign instr_read = iread_q;
    assign data_read  = dread_q;

endmodule
